load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: request, direction, lane data and
// byte enables out; completion strobe and read word back.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates a request, runs one word-aligned bus access
// with a 256-cycle timeout, and returns extended load data plus a fault code.
module load_store_unit (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  load_store_unit_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [1:0]        fault
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [7:0]  tcount;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        is_load;
  logic        is_store;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] ld_ext;

  // Request decode, evaluated against the live inputs at acceptance
  always_comb begin
    is_load    = mem_read & ~mem_write;
    is_store   = mem_write & ~mem_read;
    illegal    = ~(is_load | is_store)
               | (is_load  & ((funct3[1:0] == 2'b11) | (funct3 == 3'b110)))
               | (is_store & (funct3[2] | (funct3[1:0] == 2'b11)));
    misaligned = ((funct3[1:0] == 2'b01) & addr[0])
               | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << addr[1:0];
        wdata_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << addr[1:0];
        wdata_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = wdata;
      end
    endcase
  end

  always_comb begin
    shifted = bus.bus_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_ext = {24'd0, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_ext = {16'd0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      tcount        <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rdata         <= '0;
      fault         <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (illegal) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 2'b10;
            end else if (misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 2'b01;
            end else begin
              state         <= REQ;
              tcount        <= '0;
              f3_q          <= funct3;
              off_q         <= addr[1:0];
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= is_store;
              bus.bus_addr  <= {addr[31:2], 2'b00};
              bus.bus_be    <= be_n;
              bus.bus_wdata <= wdata_n;
            end
          end
        end
        REQ: begin
          // An ack on the final counted cycle still wins over the timeout
          if (bus.bus_ack) begin
            state       <= DONE;
            done        <= 1'b1;
            fault       <= 2'b00;
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) rdata <= ld_ext;
          end else if (tcount == 8'hFF) begin
            state       <= DONE;
            done        <= 1'b1;
            fault       <= 2'b11;
            bus.bus_req <= 1'b0;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit: a stimulus process queues
// expected bus activity and completions; monitors compare as the DUT responds.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  fault;

  load_store_unit_if bif();

  load_store_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .bus       (bif),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fault;
    logic [31:0] rdata;
    int unsigned lat;
    int unsigned issue_cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int unsigned ncyc;
  } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned cyc = 0;
  int unsigned cur_lat = 0;
  logic [31:0] cur_rdata = '0;
  bit          spur_en = 1'b0;
  logic [31:0] model_rdata = '0;

  // monitor state
  bit          prev_done = 1'b0;
  bit          in_req = 1'b0;
  int unsigned reqcnt = 0;
  bus_t        cur;
  exp_t        got;
  int unsigned rc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Reference: access size in bytes, lane offset and extension from the ISA rules
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdat, input int unsigned lat,
                                output exp_t e, output bus_t b, output bit use_bus);
    int unsigned size, off;
    logic [31:0] mask, v;
    bit legal;
    off     = a % 4;
    size    = 1 << f3[1:0];
    use_bus = 1'b0;
    b       = '{we: 1'b0, addr: '0, wdata: '0, be: '0, ncyc: 0};
    e       = '{fault: 2'd0, rdata: model_rdata, lat: 0, issue_cyc: 0};
    if (rd == wr)  legal = 1'b0;
    else if (rd)   legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    else           legal = (f3 <= 3'd2);
    if (!legal) begin
      e.fault = 2'd2;
      e.lat   = 1;
    end else if (a % size != 0) begin
      e.fault = 2'd1;
      e.lat   = 1;
    end else begin
      use_bus = 1'b1;
      b.we    = wr;
      b.addr  = a - off;
      b.be    = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      b.ncyc  = (lat > 255) ? 256 : lat + 1;
      e.lat   = (lat > 255) ? 257 : lat + 2;
      if (lat > 255) begin
        e.fault = 2'd3;
      end else begin
        e.fault = 2'd0;
        if (rd) begin
          mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
          v    = (rdat >> (8*off)) & mask;
          if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
          e.rdata     = v;
          model_rdata = v;
        end
      end
    end
  endfunction

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int unsigned lat);
    exp_t e;
    bus_t b;
    bit   use_bus;
    model(rd, wr, f3, a, wd, rdat, lat, e, b, use_bus);
    e.issue_cyc = cyc;
    exp_q.push_back(e);
    if (use_bus) bus_q.push_back(b);
    cur_lat   = lat;
    cur_rdata = rdat;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    start     = 1'b1;
  endtask

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  task automatic wait_idle(input bit noise);
    int unsigned n = 0;
    @(negedge clk);
    start = 1'b0;
    while (busy) begin
      if (noise) begin
        {start, mem_read, mem_write, funct3} = 6'($urandom);
        addr  = $urandom;
        wdata = $urandom;
      end
      n++;
      if (n > 600) begin
        compared++;
        mismatched++;
        $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", n);
        finish_now();
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory responder: acks after cur_lat REQ cycles, random ack noise outside REQ
  initial begin
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bif.bus_req) begin
        bif.bus_ack   = (rc == cur_lat);
        bif.bus_rdata = cur_rdata;
        rc++;
      end else begin
        rc            = 0;
        bif.bus_ack   = spur_en && ($urandom_range(1, 0) == 1);
        bif.bus_rdata = $urandom;
      end
    end
  end

  // Completion and bus monitor
  initial begin
    cur = '{we: 1'b0, addr: '0, wdata: '0, be: '0, ncyc: 0};
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_done = 1'b0;
        in_req    = 1'b0;
      end else begin
        if (done) begin
          check("done_single_cycle", 32'(prev_done), 32'd0);
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL extra_done: got done=1 expected done=0 (no request outstanding)");
          end else begin
            got = exp_q.pop_front();
            check("rdata", rdata, got.rdata);
            check("fault", 32'(fault), 32'(got.fault));
            check("latency", cyc - got.issue_cyc, got.lat);
          end
        end
        prev_done = done;
        if (bif.bus_req) begin
          if (!in_req) begin
            in_req = 1'b1;
            reqcnt = 1;
            if (bus_q.size() == 0) begin
              compared++;
              mismatched++;
              $display("FAIL unexpected_req: got bus_req=1 expected bus_req=0");
              cur = '{we: 1'b0, addr: '0, wdata: '0, be: '0, ncyc: 0};
            end else begin
              cur = bus_q.pop_front();
              check("bus_we", 32'(bif.bus_we), 32'(cur.we));
              check("bus_addr", bif.bus_addr, cur.addr);
              check("bus_be", 32'(bif.bus_be), 32'(cur.be));
              check("bus_wdata", bif.bus_wdata, cur.wdata);
            end
          end else begin
            reqcnt++;
            check("bus_stable_ctl", {27'd0, bif.bus_we, bif.bus_be}, {27'd0, cur.we, cur.be});
            check("bus_stable_addr", bif.bus_addr, cur.addr);
            check("bus_stable_wdata", bif.bus_wdata, cur.wdata);
          end
        end else if (in_req) begin
          in_req = 1'b0;
          check("req_cycles", reqcnt, cur.ncyc);
        end
      end
    end
  end

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int unsigned lat, r;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bus_req", 32'(bif.bus_req), 32'd0);
    check("rst_bus_we", 32'(bif.bus_we), 32'd0);
    check("rst_bus_addr", bif.bus_addr, 32'd0);
    check("rst_bus_wdata", bif.bus_wdata, 32'd0);
    check("rst_bus_be", 32'(bif.bus_be), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed accesses
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80AA_BBCC, 0);
    wait_idle(1'b0);
    check("lb_const", rdata, 32'hFFFF_FF80);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 0);
    wait_idle(1'b0);
    issue(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'hABCD_0000, 0);
    wait_idle(1'b0);
    check("lhu_const", rdata, 32'h0000_ABCD);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 0);
    wait_idle(1'b0);
    check("lw_misaligned_fault", 32'(fault), 32'd1);
    issue(1'b0, 1'b1, 3'b011, 32'h0000_3000, 32'hDEAD_BEEF, 32'd0, 0);
    wait_idle(1'b0);
    issue(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'd0, 32'd0, 0);
    wait_idle(1'b0);
    issue(1'b0, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 32'd0, 0);
    wait_idle(1'b0);
    issue(1'b1, 1'b0, 3'b110, 32'h0000_3001, 32'd0, 32'd0, 0);
    wait_idle(1'b0);

    // Timeout and ack on the last counted cycle
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'h1111_2222, 1000);
    wait_idle(1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'd0, 32'h3333_4444, 255);
    wait_idle(1'b0);

    // Busy-time start noise and spurious acks
    spur_en = 1'b1;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_5006, 32'd0, 32'h8001_7FFF, 3);
    wait_idle(1'b1);
    issue(1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'd0, 2);
    wait_idle(1'b1);

    // Reset in the middle of a bus access
    issue(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 32'h5555_AAAA, 1000);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_bus_req", 32'(bif.bus_req), 32'd0);
    check("midrst_bus_we", 32'(bif.bus_we), 32'd0);
    check("midrst_bus_addr", bif.bus_addr, 32'd0);
    check("midrst_bus_wdata", bif.bus_wdata, 32'd0);
    check("midrst_bus_be", 32'(bif.bus_be), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_fault", 32'(fault), 32'd0);
    exp_q.delete();
    bus_q.delete();
    model_rdata = '0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_6008, 32'd0, 32'hCAFE_F00D, 0);
    wait_idle(1'b0);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(9, 0);
      if (r == 0) begin
        {rd, wr} = 2'($urandom);
        f3 = 3'($urandom);
      end else if (r < 6) begin
        rd = 1'b1;
        wr = 1'b0;
        case ($urandom_range(4, 0))
          0:       f3 = 3'b000;
          1:       f3 = 3'b001;
          2:       f3 = 3'b010;
          3:       f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        rd = 1'b0;
        wr = 1'b1;
        f3 = 3'($urandom_range(2, 0));
      end
      if (r == 9) f3 = 3'($urandom);
      a   = $urandom;
      lat = $urandom_range(6, 0);
      issue(rd, wr, f3, a, $urandom, $urandom, lat);
      wait_idle(i % 2 == 1);
    end

    repeat (3) @(negedge clk);
    check("pending_completions", exp_q.size(), 32'd0);
    check("pending_bus", bus_q.size(), 32'd0);
    finish_now();
  end

endmodule
